// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Request/response data-bus interface between the load/store
//               unit (master) and the data memory / bus fabric (slave).
//               Request : req_valid, req_ready, req_write, req_addr,
//                         req_wdata, req_wstrb
//               Response: rsp_valid, rsp_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_wstrb;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;

    modport master (
        output req_valid,
        input  req_ready,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_wstrb,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_wstrb,
        output rsp_valid,
        output rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit. Turns a load/store from the execution stage
//               into a single request/response bus transaction, stalls the
//               core until it completes and returns aligned, extended load
//               data for write-back. Misaligned H/W accesses are flagged and
//               never reach the bus.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               mem_read/mem_write- instruction is a load / store
//               mem_opcode        - funct3 size/sign encoding
//               addr, wdata       - byte address, store data (rs2)
//               bus               - lsu_if master (request/response bus)
//               lsu_stall         - hold PC/architectural state
//               lsu_done          - one-cycle completion pulse
//               lsu_rdata         - formatted load data (valid with done)
//               lsu_misalign      - one-cycle misaligned-access pulse
// Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN    = 32,
    parameter int MEMOP_W = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               mem_read,
    input  wire logic               mem_write,
    input  wire logic [MEMOP_W-1:0] mem_opcode,
    input  wire logic [XLEN-1:0]    addr,
    input  wire logic [XLEN-1:0]    wdata,
    lsu_if.master                   bus,
    output logic                    lsu_stall,
    output logic                    lsu_done,
    output logic [XLEN-1:0]         lsu_rdata,
    output logic                    lsu_misalign
);

    // funct3[1:0] selects the size; funct3[2] selects zero-extension.
    // Every size code other than B/H (including 011/110/111) acts as W.
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_req_write;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_req_wdata;
    logic [3:0]      r_req_wstrb;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [1:0]      r_off;

    logic            w_access;
    logic            w_misalign;
    logic            w_launch;
    logic            w_req_valid;
    logic [XLEN-1:0] w_lane_wdata;
    logic [3:0]      w_lane_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // ------------------------------------------------------------------
    // Access decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_access   = mem_read | mem_write;
        w_misalign = 1'b0;
        if (mem_opcode[1:0] == c_SZ_H)
            w_misalign = addr[0];
        else if (mem_opcode[1:0] != c_SZ_B)
            w_misalign = (addr[1:0] != 2'b00);
    end

    // Store lane replication: the bus picks the bytes via the strobes, so
    // the data is simply copied into every lane.
    always_comb begin
        w_lane_wdata = wdata;
        w_lane_wstrb = 4'b1111;
        case (mem_opcode[1:0])
            c_SZ_B: begin
                w_lane_wdata = {4{wdata[7:0]}};
                w_lane_wstrb = 4'b0001 << addr[1:0];
            end
            c_SZ_H: begin
                w_lane_wdata = {2{wdata[15:0]}};
                w_lane_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_lane_wdata = wdata;
                w_lane_wstrb = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs. Stall drops in the done cycle so the
    // core retires the instruction and does not relaunch the access.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_req_valid  = 1'b0;
        w_launch     = 1'b0;
        lsu_stall    = 1'b0;
        lsu_done     = 1'b0;
        lsu_misalign = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_misalign) begin
                        lsu_misalign = 1'b1;
                    end else begin
                        w_launch    = 1'b1;
                        lsu_stall   = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                lsu_stall   = 1'b1;
                if (bus.req_ready)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_valid) begin
                    lsu_done    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    lsu_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture: fields are latched once at launch so the request
    // stays stable through REQ regardless of what the core drives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= 4'b0000;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
        end else if (w_launch) begin
            r_req_write <= mem_write;
            r_req_addr  <= {addr[XLEN-1:2], 2'b00};
            r_req_wdata <= w_lane_wdata;
            r_req_wstrb <= mem_write ? w_lane_wstrb : 4'b0000;
            r_size      <= mem_opcode[1:0];
            r_unsigned  <= mem_opcode[2];
            r_off       <= addr[1:0];
        end
    end

    assign bus.req_valid = w_req_valid;
    assign bus.req_write = r_req_write;
    assign bus.req_addr  = r_req_addr;
    assign bus.req_wdata = r_req_wdata;
    assign bus.req_wstrb = r_req_wstrb;

    // ------------------------------------------------------------------
    // Load formatting from the raw bus word using the captured offset
    // ------------------------------------------------------------------
    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus.rsp_rdata[7:0];
            2'd1:    w_byte = bus.rsp_rdata[15:8];
            2'd2:    w_byte = bus.rsp_rdata[23:16];
            default: w_byte = bus.rsp_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.rsp_rdata[31:16] : bus.rsp_rdata[15:0];

        case (r_size)
            c_SZ_B:  lsu_rdata = r_unsigned ? {24'd0, w_byte}
                                            : {{24{w_byte[7]}}, w_byte};
            c_SZ_H:  lsu_rdata = r_unsigned ? {16'd0, w_half}
                                            : {{16{w_half[15]}}, w_half};
            default: lsu_rdata = bus.rsp_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking testbench for lsu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    lsu_if #(.XLEN(32)) bus ();

    lsu #(.XLEN(32), .MEMOP_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_opcode   (mem_opcode),
        .addr         (addr),
        .wdata        (wdata),
        .bus          (bus),
        .lsu_stall    (lsu_stall),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .lsu_misalign (lsu_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes that will complete at the next rising edge.
    always @(negedge clk) if (bus.req_valid && bus.req_ready) hs_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_opcode    = 3'b010;
        addr          = 32'h0;
        wdata         = 32'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.req_valid); end
        checks++; if (bus.req_write !== 1'b0) begin errors++; $display("FAIL rst_req_write: got %b want 0", bus.req_write); end
        checks++; if (bus.req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h want 0", bus.req_addr); end
        checks++; if (bus.req_wdata !== 32'h0) begin errors++; $display("FAIL rst_req_wdata: got %h want 0", bus.req_wdata); end
        checks++; if (bus.req_wstrb !== 4'h0) begin errors++; $display("FAIL rst_req_wstrb: got %b want 0000", bus.req_wstrb); end
        checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", lsu_done); end
        checks++; if (lsu_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", lsu_misalign); end
        rst = 1'b0;
        step();
        checks++; if (lsu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", lsu_stall); end
    endtask

    task automatic test_lw_wait();
        step();
        mem_read = 1'b1; mem_opcode = 3'b010; addr = 32'h1000; bus.req_ready = 1'b0;
        #1;
        checks++; if (lsu_stall !== 1'b1) begin errors++; $display("FAIL lw_idle_stall: got %b want 1", lsu_stall); end
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL lw_idle_valid: got %b want 0", bus.req_valid); end
        step(); #1;
        checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL lw_req_valid: got %b want 1", bus.req_valid); end
        checks++; if (bus.req_addr !== 32'h1000) begin errors++; $display("FAIL lw_req_addr: got %h want 00001000", bus.req_addr); end
        checks++; if (bus.req_wstrb !== 4'h0) begin errors++; $display("FAIL lw_req_wstrb: got %b want 0000", bus.req_wstrb); end
        checks++; if (bus.req_write !== 1'b0) begin errors++; $display("FAIL lw_req_write: got %b want 0", bus.req_write); end
        step(); #1;
        checks++; if (bus.req_valid !== 1'b1 || lsu_stall !== 1'b1) begin errors++; $display("FAIL lw_hold: got valid=%b stall=%b want 1 1", bus.req_valid, lsu_stall); end
        step();
        bus.req_ready = 1'b1;
        #1;
        checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL lw_hold2: got %b want 1", bus.req_valid); end
        step();
        bus.req_ready = 1'b0;
        #1;
        checks++; if (lsu_stall !== 1'b1 || lsu_done !== 1'b0 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_wait: got stall=%b done=%b valid=%b want 1 0 0", lsu_stall, lsu_done, bus.req_valid); end
        step();
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (lsu_done !== 1'b1) begin errors++; $display("FAIL lw_done: got %b want 1", lsu_done); end
        checks++; if (lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", lsu_rdata); end
        checks++; if (lsu_stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall: got %b want 0", lsu_stall); end
        step();
        clear_inputs();
        #1;
        checks++; if (lsu_done !== 1'b0 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL lw_after: got done=%b valid=%b want 0 0", lsu_done, bus.req_valid); end
    endtask

    task automatic test_load_format();
        logic [2:0]  ops  [0:7];
        logic [31:0] adrs [0:7];
        logic [31:0] exps [0:7];
        ops  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001, 3'b011, 3'b100};
        adrs = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2001, 32'h2000, 32'h2000, 32'h2002};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012,
                 32'h00000034, 32'h00003456, 32'h80123456, 32'h00000012};
        for (int i = 0; i < 8; i++) begin
            step();
            mem_read = 1'b1; mem_opcode = ops[i]; addr = adrs[i]; bus.req_ready = 1'b1;
            step(); #1;
            checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h2000) begin errors++; $display("FAIL ld%0d_req: got valid=%b addr=%h want 1 00002000", i, bus.req_valid, bus.req_addr); end
            step();
            bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h80123456;
            #1;
            checks++; if (lsu_done !== 1'b1 || lsu_rdata !== exps[i]) begin errors++; $display("FAIL ld%0d_data: got done=%b data=%h want 1 %h", i, lsu_done, lsu_rdata, exps[i]); end
            step();
            clear_inputs();
        end
    endtask

    task automatic test_store();
        logic [2:0]  ops   [0:3];
        logic [31:0] adrs  [0:3];
        logic [31:0] wds   [0:3];
        logic [31:0] eaddr [0:3];
        logic [31:0] ewd   [0:3];
        logic [3:0]  estb  [0:3];
        ops   = '{3'b001, 3'b000, 3'b010, 3'b000};
        adrs  = '{32'h3002, 32'h3001, 32'h3004, 32'h3003};
        wds   = '{32'h0000ABCD, 32'h123456EF, 32'h11223344, 32'h0000005A};
        eaddr = '{32'h3000, 32'h3000, 32'h3004, 32'h3000};
        ewd   = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h11223344, 32'h5A5A5A5A};
        estb  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            step();
            mem_write = 1'b1; mem_opcode = ops[i]; addr = adrs[i]; wdata = wds[i]; bus.req_ready = 1'b1;
            step(); #1;
            checks++; if (bus.req_write !== 1'b1 || bus.req_addr !== eaddr[i]) begin errors++; $display("FAIL st%0d_wr_addr: got write=%b addr=%h want 1 %h", i, bus.req_write, bus.req_addr, eaddr[i]); end
            checks++; if (bus.req_wdata !== ewd[i] || bus.req_wstrb !== estb[i]) begin errors++; $display("FAIL st%0d_lane: got wdata=%h wstrb=%b want %h %b", i, bus.req_wdata, bus.req_wstrb, ewd[i], estb[i]); end
            step();
            bus.rsp_valid = 1'b1;
            #1;
            checks++; if (lsu_done !== 1'b1 || lsu_stall !== 1'b0) begin errors++; $display("FAIL st%0d_done: got done=%b stall=%b want 1 0", i, lsu_done, lsu_stall); end
            step();
            clear_inputs();
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  ops  [0:3];
        logic [31:0] adrs [0:3];
        logic        wr   [0:3];
        ops  = '{3'b010, 3'b001, 3'b101, 3'b010};
        adrs = '{32'h4002, 32'h4001, 32'h4003, 32'h4001};
        wr   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            mem_read = ~wr[i]; mem_write = wr[i]; mem_opcode = ops[i]; addr = adrs[i];
            bus.req_ready = 1'b1;
            #1;
            checks++; if (lsu_misalign !== 1'b1 || lsu_stall !== 1'b0 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL mis%0d_flag: got mis=%b stall=%b valid=%b want 1 0 0", i, lsu_misalign, lsu_stall, bus.req_valid); end
            step();
            clear_inputs();
            #1;
            checks++; if (bus.req_valid !== 1'b0 || lsu_misalign !== 1'b0) begin errors++; $display("FAIL mis%0d_after: got valid=%b mis=%b want 0 0", i, bus.req_valid, lsu_misalign); end
        end
    endtask

    task automatic test_reset_mid();
        step();
        mem_read = 1'b1; mem_opcode = 3'b010; addr = 32'h6000; bus.req_ready = 1'b1;
        step();
        step();
        bus.req_ready = 1'b0;
        #1;
        checks++; if (lsu_stall !== 1'b1) begin errors++; $display("FAIL rmid_resp_stall: got %b want 1", lsu_stall); end
        rst = 1'b1;
        mem_read = 1'b0;
        #1;
        checks++; if (bus.req_valid !== 1'b0 || lsu_stall !== 1'b0 || bus.req_addr !== 32'h0) begin errors++; $display("FAIL rmid_async: got valid=%b stall=%b addr=%h want 0 0 00000000", bus.req_valid, lsu_stall, bus.req_addr); end
        step();
        rst = 1'b0;
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (lsu_done !== 1'b0 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL rmid_late_rsp: got done=%b valid=%b want 0 0", lsu_done, bus.req_valid); end
        step();
        clear_inputs();
        #1;
        checks++; if (lsu_done !== 1'b0 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL rmid_after: got done=%b valid=%b want 0 0", lsu_done, bus.req_valid); end
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = hs_cnt;
        step();
        mem_write = 1'b1; mem_opcode = 3'b010; addr = 32'h5000; wdata = 32'h11223344; bus.req_ready = 1'b1;
        #1;
        checks++; if (lsu_stall !== 1'b1) begin errors++; $display("FAIL b2b_sw_launch: got stall=%b want 1", lsu_stall); end
        step(); #1;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_write !== 1'b1 || bus.req_wstrb !== 4'b1111) begin errors++; $display("FAIL b2b_sw_req: got valid=%b write=%b wstrb=%b want 1 1 1111", bus.req_valid, bus.req_write, bus.req_wstrb); end
        step();
        bus.rsp_valid = 1'b1;
        #1;
        checks++; if (lsu_done !== 1'b1) begin errors++; $display("FAIL b2b_sw_done: got %b want 1", lsu_done); end
        step();
        bus.rsp_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
        #1;
        checks++; if (lsu_stall !== 1'b1 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL b2b_lw_launch: got stall=%b valid=%b want 1 0", lsu_stall, bus.req_valid); end
        step(); #1;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_write !== 1'b0 || bus.req_addr !== 32'h5000) begin errors++; $display("FAIL b2b_lw_req: got valid=%b write=%b addr=%h want 1 0 00005000", bus.req_valid, bus.req_write, bus.req_addr); end
        step();
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h11223344;
        #1;
        checks++; if (lsu_done !== 1'b1 || lsu_rdata !== 32'h11223344) begin errors++; $display("FAIL b2b_lw_done: got done=%b data=%h want 1 11223344", lsu_done, lsu_rdata); end
        step();
        clear_inputs();
        bus.req_ready = 1'b1;
        step();
        step(); #1;
        checks++; if (hs_cnt - hs0 !== 2 || bus.req_valid !== 1'b0) begin errors++; $display("FAIL b2b_req_count: got %0d requests valid=%b want 2 0", hs_cnt - hs0, bus.req_valid); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_load_format();
        test_store();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
